// File: rtl/zx_video_pkg.sv
// rtl/zx_video_pkg.sv - machine timing profiles for the Spectrum raster generator
package zx_video_pkg;

    localparam int ACTIVE_W  = 256;
    localparam int ACTIVE_H  = 192;
    localparam int NPROF_MAX = 3;

    typedef struct packed {
        logic [8:0] h_total;
        logic [8:0] v_total;
        logic [8:0] hblank_s;
        logic [8:0] hblank_e;
        logic [8:0] hsync_s;
        logic [8:0] hsync_e;
        logic [8:0] vsync_s;
        logic [8:0] vsync_e;
        logic [8:0] int_line;
        logic [8:0] int_col;
        logic [6:0] int_len;
    } timing_t;

    // Range ends are exclusive: a signal is high for start <= count < end.
    localparam timing_t PROFILE [NPROF_MAX] = '{
        '{9'd448, 9'd312, 9'd312, 9'd416, 9'd336, 9'd368, 9'd240, 9'd244, 9'd248, 9'd4,   7'd64},
        '{9'd456, 9'd311, 9'd312, 9'd424, 9'd340, 9'd372, 9'd240, 9'd244, 9'd248, 9'd8,   7'd72},
        '{9'd448, 9'd320, 9'd312, 9'd420, 9'd338, 9'd370, 9'd248, 9'd256, 9'd239, 9'd326, 7'd64}
    };

    function automatic logic in_range(input logic [8:0] v, input logic [8:0] s, input logic [8:0] e);
        return (v >= s) && (v < e);
    endfunction

endpackage

// File: rtl/zx_raster_counter.sv
// rtl/zx_raster_counter.sv - hc/vc raster counters with line/frame wrap and frame_start pulse
module zx_raster_counter #(
    parameter int HC_W = 9,
    parameter int VC_W = 9
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic            ce,
    input  logic [HC_W-1:0] h_total,
    input  logic [VC_W-1:0] v_total,
    output logic [HC_W-1:0] hc,
    output logic [VC_W-1:0] vc,
    output logic [HC_W-1:0] hc_nx,
    output logic [VC_W-1:0] vc_nx,
    output logic            line_wrap,
    output logic            frame_wrap,
    output logic            frame_start
);

    logic h_last;
    logic v_last;

    always_comb begin
        h_last     = (hc == h_total - HC_W'(1));
        v_last     = (vc == v_total - VC_W'(1));
        hc_nx      = h_last ? '0 : hc + HC_W'(1);
        vc_nx      = vc;
        if (h_last)
            vc_nx = v_last ? '0 : vc + VC_W'(1);
        line_wrap  = ce & h_last;
        frame_wrap = ce & h_last & v_last;
    end

    // frame_start is a single clk_sys pulse even when ce is sparse.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hc          <= '0;
            vc          <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_wrap;
            if (ce) begin
                hc <= hc_nx;
                vc <= vc_nx;
            end
        end
    end

endmodule

// File: rtl/zx_video_timing.sv
// rtl/zx_video_timing.sv - raster timing, sync/blank decode, frame INT and raster-line IRQ
module zx_video_timing
    import zx_video_pkg::*;
#(
    parameter int NPROF = 3,
    parameter int HC_W  = 9,
    parameter int VC_W  = 9,
    parameter int PW    = $clog2(NPROF)
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic            ce_7mn,
    input  logic [PW-1:0]   prof_sel,
    input  logic            line_irq_ena,
    input  logic [VC_W-1:0] line_irq_line,
    input  logic            line_irq_ack,
    output logic [PW-1:0]   prof_active,
    output logic [HC_W-1:0] hc,
    output logic [VC_W-1:0] vc,
    output logic [3:0]      fetch_phase,
    output logic            border,
    output logic            hblank,
    output logic            hsync,
    output logic            vsync,
    output logic            nINT,
    output logic            line_irq,
    output logic            flash,
    output logic            frame_start
);

    localparam logic [PW:0] NPROF_V = (PW+1)'(NPROF);

    timing_t         t;
    logic [HC_W-1:0] hc_nx;
    logic [VC_W-1:0] vc_nx;
    logic [8:0]      h9;
    logic [8:0]      v9;
    logic            line_wrap;
    logic            frame_wrap;
    logic            int_hit;
    logic            line_set;
    logic [4:0]      flash_cnt;
    logic [6:0]      int_cnt;

    assign t = PROFILE[prof_active];

    zx_raster_counter #(
        .HC_W(HC_W),
        .VC_W(VC_W)
    ) u_cnt (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ce          (ce_7mn),
        .h_total     (HC_W'(t.h_total)),
        .v_total     (VC_W'(t.v_total)),
        .hc          (hc),
        .vc          (vc),
        .hc_nx       (hc_nx),
        .vc_nx       (vc_nx),
        .line_wrap   (line_wrap),
        .frame_wrap  (frame_wrap),
        .frame_start (frame_start)
    );

    // Decode from next-count values so each output lines up with the count it describes.
    assign h9          = 9'(hc_nx);
    assign v9          = 9'(vc_nx);
    assign int_hit     = (v9 == t.int_line) && (h9 == t.int_col);
    assign line_set    = line_wrap & line_irq_ena & (vc_nx == line_irq_line);
    assign fetch_phase = hc[3:0];
    assign flash       = flash_cnt[4];

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            prof_active <= '0;
            flash_cnt   <= '0;
            border      <= 1'b0;
            hblank      <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            nINT        <= 1'b1;
            int_cnt     <= '0;
            line_irq    <= 1'b0;
        end else begin
            if (ce_7mn) begin
                border <= (vc_nx >= VC_W'(ACTIVE_H)) | (hc_nx >= HC_W'(ACTIVE_W));
                hblank <= in_range(h9, t.hblank_s, t.hblank_e);
                hsync  <= in_range(h9, t.hsync_s, t.hsync_e);
                vsync  <= in_range(v9, t.vsync_s, t.vsync_e);
                if (frame_wrap) begin
                    flash_cnt <= flash_cnt + 5'd1;
                    if ({1'b0, prof_sel} < NPROF_V)
                        prof_active <= prof_sel;
                end
                // Length is latched at the start, so a later profile switch cannot cut the pulse short.
                if (int_hit) begin
                    nINT    <= 1'b0;
                    int_cnt <= t.int_len - 7'd1;
                end else if (!nINT) begin
                    if (int_cnt == 7'd0)
                        nINT <= 1'b1;
                    else
                        int_cnt <= int_cnt - 7'd1;
                end
            end
            if (line_set)
                line_irq <= 1'b1;
            else if (line_irq_ack)
                line_irq <= 1'b0;
        end
    end

endmodule

// File: tb/tb_zx_video_timing.sv
// tb/tb_zx_video_timing.sv - directed self-checking bench for zx_video_timing
module tb_zx_video_timing;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       ce_7mn;
    logic [1:0] prof_sel;
    logic       line_irq_ena;
    logic [8:0] line_irq_line;
    logic       line_irq_ack;
    logic [1:0] prof_active;
    logic [8:0] hc;
    logic [8:0] vc;
    logic [3:0] fetch_phase;
    logic       border, hblank, hsync, vsync, nINT, line_irq, flash, frame_start;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [8:0] jv, jh;

    zx_video_timing #(.NPROF(3), .HC_W(9), .VC_W(9), .PW(2)) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ce_7mn        (ce_7mn),
        .prof_sel      (prof_sel),
        .line_irq_ena  (line_irq_ena),
        .line_irq_line (line_irq_line),
        .line_irq_ack  (line_irq_ack),
        .prof_active   (prof_active),
        .hc            (hc),
        .vc            (vc),
        .fetch_phase   (fetch_phase),
        .border        (border),
        .hblank        (hblank),
        .hsync         (hsync),
        .vsync         (vsync),
        .nINT          (nINT),
        .line_irq      (line_irq),
        .flash         (flash),
        .frame_start   (frame_start)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // Place the raster at (v, h) so distant lines are reached without running whole frames.
    task jump(input logic [8:0] v, input logic [8:0] h);
        jv = v;
        jh = h;
        force dut.u_cnt.vc = jv;
        force dut.u_cnt.hc = jh;
        #1;
        release dut.u_cnt.vc;
        release dut.u_cnt.hc;
    endtask

    initial begin
        reset = 1'b1; ce_7mn = 1'b1; prof_sel = 2'd0;
        line_irq_ena = 1'b0; line_irq_line = 9'd0; line_irq_ack = 1'b0;
        step(2);
        chk("rst_hc", hc, 0);
        chk("rst_vc", vc, 0);
        chk("rst_nint", nINT, 1);
        chk("rst_border", border, 0);
        chk("rst_prof", prof_active, 0);
        chk("rst_flash", flash, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_blank_sync_irq", {hblank, hsync, vsync, line_irq}, 0);

        reset = 1'b0;
        step(1);   chk("first_hc", hc, 1); chk("fetch_phase", fetch_phase, 1);
        step(254); chk("hc255_border", border, 0);
        step(1);   chk("hc256_border", border, 1);
        step(55);  chk("hc311_hblank", hblank, 0);
        step(1);   chk("hc312_hblank", hblank, 1);
        step(23);  chk("hc335_hsync", hsync, 0);
        step(1);   chk("hc336_hsync", hsync, 1);
        step(31);  chk("hc367_hsync", hsync, 1);
        step(1);   chk("hc368_hsync", hsync, 0);
        step(47);  chk("hc415_hblank", hblank, 1);
        step(1);   chk("hc416_hblank", hblank, 0);
        step(31);  chk("hc447", hc, 447);
        step(1);   chk("hwrap_hc", hc, 0); chk("hwrap_vc", vc, 1); chk("hwrap_border", border, 0);

        ce_7mn = 1'b0; step(5);
        chk("ce_hold_hc", hc, 0); chk("ce_hold_vc", vc, 1);
        ce_7mn = 1'b1;

        jump(9'd190, 9'd447); step(1); chk("vc191_border", border, 0);
        jump(9'd191, 9'd447); step(1); chk("vc192_border", border, 1);
        jump(9'd239, 9'd447); step(1); chk("vc240", vc, 240); chk("vc240_vsync", vsync, 1);
        jump(9'd243, 9'd447); step(1); chk("vc244_vsync", vsync, 0);

        line_irq_ena = 1'b1; line_irq_line = 9'd50;
        jump(9'd49, 9'd446); step(1); chk("lirq_before", line_irq, 0);
        step(1);  chk("lirq_set", line_irq, 1); chk("lirq_vc", vc, 50);
        step(20); chk("lirq_sticky", line_irq, 1);
        jump(9'd49, 9'd447); line_irq_ack = 1'b1; step(1); line_irq_ack = 1'b0;
        chk("lirq_set_wins", line_irq, 1);
        ce_7mn = 1'b0; line_irq_ack = 1'b1; step(1); line_irq_ack = 1'b0; ce_7mn = 1'b1;
        chk("lirq_ack_no_ce", line_irq, 0);
        line_irq_line = 9'd400;
        jump(9'd311, 9'd446); step(1); chk("fs_before", frame_start, 0);
        step(1); chk("fwrap_vc", vc, 0); chk("fwrap_hc", hc, 0);
        chk("fs_pulse", frame_start, 1); chk("lirq_line_oob", line_irq, 0);
        step(1); chk("fs_clear", frame_start, 0);
        line_irq_ena = 1'b0;

        jump(9'd248, 9'd0); step(3); chk("int48_hc3", nINT, 1);
        step(1);  chk("int48_start", nINT, 0);
        step(63); chk("int48_tick64", nINT, 0);
        step(1);  chk("int48_end", nINT, 1);

        jump(9'd248, 9'd0); step(10); chk("int_before_rst", nINT, 0);
        reset = 1'b1; #1;
        chk("async_rst_nint", nINT, 1); chk("async_rst_hc", hc, 0); chk("async_rst_vc", vc, 0);
        step(2); reset = 1'b0;
        step(1); chk("restart_hc", hc, 1);
        jump(9'd248, 9'd0); step(4); chk("int_after_rst", nINT, 0);
        step(70); chk("int_after_rst_end", nINT, 1);

        jump(9'd100, 9'd0); prof_sel = 2'd2; step(5); chk("prof_hold", prof_active, 0);
        jump(9'd311, 9'd447); step(1); chk("prof_switch", prof_active, 2); chk("switch_vc", vc, 0);
        jump(9'd311, 9'd447); step(1); chk("pent_vc312", vc, 312);
        jump(9'd319, 9'd447); step(1); chk("pent_vwrap", vc, 0);
        jump(9'd239, 9'd320); step(5); chk("pent_int_before", nINT, 1);
        step(1); chk("pent_int_start", nINT, 0);
        step(64); chk("pent_int_end", nINT, 1);

        prof_sel = 2'd1;
        jump(9'd319, 9'd447); step(1); chk("prof1_active", prof_active, 1);
        jump(9'd0, 9'd446); step(2); chk("p1_hc448", hc, 448);
        jump(9'd0, 9'd455); step(1); chk("p1_hwrap_hc", hc, 0); chk("p1_hwrap_vc", vc, 1);
        jump(9'd310, 9'd455); step(1); chk("p1_vwrap", vc, 0);
        jump(9'd5, 9'd338); step(1); chk("p1_hsync339", hsync, 0);
        step(1); chk("p1_hsync340", hsync, 1);
        jump(9'd5, 9'd370); step(1); chk("p1_hsync371", hsync, 1);
        step(1); chk("p1_hsync372", hsync, 0);
        jump(9'd248, 9'd0); step(7); chk("p1_int_hc7", nINT, 1);
        step(1);  chk("p1_int_start", nINT, 0);
        step(71); chk("p1_int_tick72", nINT, 0);
        step(1);  chk("p1_int_end", nINT, 1);

        jump(9'd248, 9'd0); step(8); chk("sw_int_start", nINT, 0);
        prof_sel = 2'd0;
        jump(9'd310, 9'd455); step(64);
        chk("sw_int_prof", prof_active, 0); chk("sw_int_tick65", nINT, 0);
        step(7); chk("sw_int_tick72", nINT, 0);
        step(1); chk("sw_int_end", nINT, 1);

        prof_sel = 2'd3;
        jump(9'd311, 9'd447); step(1); chk("prof_sel_oob", prof_active, 0);

        reset = 1'b1; step(1); reset = 1'b0; step(1);
        for (int i = 1; i <= 32; i++) begin
            jump(9'd311, 9'd447); step(1);
            chk($sformatf("flash_wrap%0d", i), flash, (i >> 4) & 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
